// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single SDRAM request port between the CPU
// (read/write) and VGA scanout (read-only). One transaction is outstanding at
// a time; VGA wins arbitration unless the CPU has been starved too long, and
// every transaction is bounded by a completion timeout.
module sdram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 22,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CPU_STARVE = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  input  logic                  vga_req,
  output logic [DATA_WIDTH-1:0] vga_data_out,
  output logic                  vga_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_req,
  output logic                  mem_write,
  input  logic                  mem_ready,
  input  logic                  mem_done,
  output logic                  timeout_err,
  output logic                  busy,
  output logic                  grant_vga
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(CPU_STARVE);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic       op_write;
  logic       aborted;
  logic [3:0] starve;
  logic [7:0] tcnt;
  logic       cpu_pending;
  logic       take_vga;
  logic       take_cpu;
  logic       complete;
  logic       expire;

  // Arbitration decision and completion/timeout qualifiers
  always_comb begin
    cpu_pending = cpu_req | cpu_write;
    take_vga    = vga_req & ~(cpu_pending & (starve >= STARVE_LIM));
    take_cpu    = ~take_vga & cpu_pending;
    complete    = op_write ? mem_done : mem_ready;
    expire      = (tcnt == TMO_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a completion in the final WAIT cycle beats the timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_vga || take_cpu) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (complete || expire) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and response pulses decoded from the registered state
  always_comb begin
    mem_req     = (state == ISSUE) & ~op_write;
    mem_write   = (state == ISSUE) &  op_write;
    cpu_ready   = (state == RESP)  & ~grant_vga & ~op_write;
    cpu_done    = (state == RESP)  & ~grant_vga &  op_write;
    vga_ready   = (state == RESP)  &  grant_vga;
    timeout_err = (state == RESP)  &  aborted;
    busy        = (state != IDLE);
  end

  // Grant latching, starvation tracking, timeout counting and read capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr     <= '0;
      mem_data_out <= '0;
      op_write     <= 1'b0;
      grant_vga    <= 1'b0;
      starve       <= '0;
      tcnt         <= '0;
      aborted      <= 1'b0;
      cpu_data_out <= '0;
      vga_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_vga) begin
            mem_addr     <= vga_addr;
            mem_data_out <= cpu_data_in;
            op_write     <= 1'b0;
            grant_vga    <= 1'b1;
            if (cpu_pending && starve != 4'hF) starve <= starve + 4'd1;
          end else if (take_cpu) begin
            mem_addr     <= cpu_addr;
            mem_data_out <= cpu_data_in;
            op_write     <= cpu_write;
            grant_vga    <= 1'b0;
            starve       <= '0;
          end
        end
        ISSUE: begin
          tcnt    <= '0;
          aborted <= 1'b0;
        end
        WAIT: begin
          if (complete) begin
            if (!op_write) begin
              if (grant_vga) vga_data_out <= mem_data_in;
              else           cpu_data_out <= mem_data_in;
            end
          end else if (expire) begin
            aborted <= 1'b1;
            if (!op_write) begin
              if (grant_vga) vga_data_out <= '1;
              else           cpu_data_out <= '1;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus a randomized
// transaction-level run against a reference model of the arbitration rules.
module tb_sdram_arbiter;

  localparam int AW     = 22;
  localparam int DW     = 32;
  localparam int STARVE = 4;
  localparam int TMO    = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_in;
  logic          cpu_req;
  logic          cpu_write;
  logic [DW-1:0] cpu_data_out;
  logic          cpu_ready;
  logic          cpu_done;
  logic [AW-1:0] vga_addr;
  logic          vga_req;
  logic [DW-1:0] vga_data_out;
  logic          vga_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in;
  logic          mem_req;
  logic          mem_write;
  logic          mem_ready;
  logic          mem_done;
  logic          timeout_err;
  logic          busy;
  logic          grant_vga;

  sdram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CPU_STARVE(STARVE),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_req(cpu_req),
    .cpu_write(cpu_write), .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
    .cpu_done(cpu_done), .vga_addr(vga_addr), .vga_req(vga_req),
    .vga_data_out(vga_data_out), .vga_ready(vga_ready), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_req(mem_req),
    .mem_write(mem_write), .mem_ready(mem_ready), .mem_done(mem_done),
    .timeout_err(timeout_err), .busy(busy), .grant_vga(grant_vga)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory model controls: latency after strobe (0 = never answers),
  // read value, and wrong-kind stray completions (0 off, 1 random, 2 always).
  int            mem_lat      = 2;
  logic [DW-1:0] mem_rd_value = '0;
  int            stray_mode   = 0;

  // Expected data outputs, maintained by the tests
  logic [DW-1:0] cpu_exp = '0;
  logic [DW-1:0] vga_exp = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder
  initial begin : responder
    int pend;
    bit pend_wr;
    pend = 0;
    pend_wr = 1'b0;
    mem_ready = 1'b0;
    mem_done = 1'b0;
    mem_data_in = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_done  = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            if (pend_wr) mem_done = 1'b1;
            else begin
              mem_ready   = 1'b1;
              mem_data_in = mem_rd_value;
            end
          end else if (stray_mode == 2 || (stray_mode == 1 && $urandom_range(0, 2) == 0)) begin
            mem_data_in = DW'($urandom);
            if (pend_wr) mem_ready = 1'b1;
            else         mem_done  = 1'b1;
          end
        end
        if ((mem_req || mem_write) && mem_lat > 0) begin
          pend    = mem_lat;
          pend_wr = mem_write;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    cpu_addr = '0; cpu_data_in = '0; cpu_req = 1'b0; cpu_write = 1'b0;
    vga_addr = '0; vga_req = 1'b0;
    #2;
    tests++;
    if ({cpu_ready, cpu_done, vga_ready, mem_req, mem_write, timeout_err, busy, grant_vga} !== 8'b0)
      begin fails++; $display("FAIL reset_ctrl: got %b expected 00000000",
        {cpu_ready, cpu_done, vga_ready, mem_req, mem_write, timeout_err, busy, grant_vga}); end
    tests++;
    if ({mem_addr, mem_data_out, cpu_data_out, vga_data_out} !== '0)
      begin fails++; $display("FAIL reset_data: got %h %h %h %h expected all 0",
        mem_addr, mem_data_out, cpu_data_out, vga_data_out); end
    step(); step();
    reset = 1'b0;
    cpu_exp = '0; vga_exp = '0;
    step();
  endtask

  task automatic test_cpu_read();
    int strobes = 0, strobe_cyc = -1, rdy_cyc = -1, bad_wr = 0;
    logic [AW-1:0] addr_at = '0;
    mem_lat = 2; mem_rd_value = 32'hDEADBEEF; stray_mode = 0;
    cpu_addr = 22'h000100; cpu_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (mem_req) begin strobes++; strobe_cyc = c; addr_at = mem_addr; end
      if (mem_write) bad_wr++;
      if (cpu_ready && rdy_cyc < 0) begin rdy_cyc = c; cpu_req = 1'b0; end
    end
    tests++;
    if (strobes != 1 || strobe_cyc != 1 || bad_wr != 0)
      begin fails++; $display("FAIL rd_strobe: got count %0d cycle %0d writes %0d expected 1 1 0",
        strobes, strobe_cyc, bad_wr); end
    tests++;
    if (addr_at !== 22'h000100)
      begin fails++; $display("FAIL rd_addr: got %h expected 000100", addr_at); end
    tests++;
    if (rdy_cyc != 4)
      begin fails++; $display("FAIL rd_latency: got cycle %0d expected 4", rdy_cyc); end
    tests++;
    if (cpu_data_out !== 32'hDEADBEEF)
      begin fails++; $display("FAIL rd_data: got %h expected deadbeef", cpu_data_out); end
    cpu_exp = 32'hDEADBEEF;
    // A VGA read must not disturb the CPU data register
    mem_rd_value = 32'h5A5A5A5A; vga_addr = 22'h2ABCD; vga_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (vga_ready) vga_req = 1'b0;
    end
    vga_exp = 32'h5A5A5A5A;
    tests++;
    if (cpu_data_out !== cpu_exp || vga_data_out !== vga_exp)
      begin fails++; $display("FAIL rd_hold: got cpu %h vga %h expected %h %h",
        cpu_data_out, vga_data_out, cpu_exp, vga_exp); end
  endtask

  task automatic test_cpu_write();
    int wr_cnt = 0, rd_cnt = 0, done_cyc = -1, ready_cnt = 0;
    logic [DW-1:0] data_at = '0;
    mem_lat = 3; stray_mode = 2;
    cpu_addr = 22'h3; cpu_data_in = 32'h12345678; cpu_write = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (mem_write) begin wr_cnt++; data_at = mem_data_out; end
      if (mem_req) rd_cnt++;
      if (cpu_ready) ready_cnt++;
      if (cpu_done && done_cyc < 0) begin done_cyc = c; cpu_write = 1'b0; end
    end
    stray_mode = 0;
    tests++;
    if (wr_cnt != 1 || rd_cnt != 0 || data_at !== 32'h12345678)
      begin fails++; $display("FAIL wr_strobe: got wr %0d rd %0d data %h expected 1 0 12345678",
        wr_cnt, rd_cnt, data_at); end
    tests++;
    if (done_cyc != 5 || ready_cnt != 0)
      begin fails++; $display("FAIL wr_done: got done cycle %0d ready %0d expected 5 0",
        done_cyc, ready_cnt); end
    tests++;
    if (cpu_data_out !== cpu_exp)
      begin fails++; $display("FAIL wr_stray: got %h expected %h", cpu_data_out, cpu_exp); end
  endtask

  task automatic test_contention();
    int g = 0;
    int resp = 0;
    logic [9:0] seen = '0;
    mem_lat = 1; mem_rd_value = 32'hC0FFEE00; stray_mode = 0;
    vga_addr = 22'h10; cpu_addr = 22'h20; vga_req = 1'b1; cpu_req = 1'b1;
    for (int c = 0; c < 120 && g < 10; c++) begin
      step();
      if (mem_req) begin seen[g] = grant_vga; g++; end
    end
    for (int c = 0; c < 10 && resp == 0; c++) begin
      step();
      if (vga_ready || cpu_ready) resp = 1;
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    step();
    cpu_exp = 32'hC0FFEE00; vga_exp = 32'hC0FFEE00;
    tests++;
    if (g != 10 || resp != 1)
      begin fails++; $display("FAIL cont_count: got %0d grants resp %0d expected 10 1", g, resp); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (seen[i] !== ((i % (STARVE + 1)) != STARVE))
        begin fails++; $display("FAIL cont_grant%0d: got vga=%b expected vga=%b",
          i, seen[i], (i % (STARVE + 1)) != STARVE); end
    end
  endtask

  task automatic test_timeout();
    int rdy_cyc = -1, terr_cnt = 0;
    logic terr_at = 1'b0;
    logic [DW-1:0] data_at = '0;
    mem_lat = 0; stray_mode = 0;
    vga_addr = 22'h3FFFF; vga_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (timeout_err) terr_cnt++;
      if (vga_ready && rdy_cyc < 0) begin
        rdy_cyc = c; terr_at = timeout_err; data_at = vga_data_out; vga_req = 1'b0;
      end
    end
    vga_exp = '1;
    tests++;
    if (rdy_cyc != 2 + TMO)
      begin fails++; $display("FAIL tmo_cycle: got %0d expected %0d", rdy_cyc, 2 + TMO); end
    tests++;
    if (terr_at !== 1'b1 || terr_cnt != 1)
      begin fails++; $display("FAIL tmo_err: got %b count %0d expected 1 1", terr_at, terr_cnt); end
    tests++;
    if (data_at !== 32'hFFFFFFFF)
      begin fails++; $display("FAIL tmo_data: got %h expected ffffffff", data_at); end
  endtask

  task automatic test_write_and_read();
    int strobes = 0, done_cyc = -1, rdy_cyc = -1;
    logic first_wr = 1'b0;
    mem_lat = 2; mem_rd_value = 32'h0BADF00D; stray_mode = 0;
    cpu_addr = 22'h1234; cpu_data_in = 32'hA5A5F0F0; cpu_write = 1'b1; cpu_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (mem_req || mem_write) begin
        if (strobes == 0) first_wr = mem_write;
        strobes++;
      end
      if (cpu_done && done_cyc < 0) begin done_cyc = c; cpu_write = 1'b0; end
      if (cpu_ready && rdy_cyc < 0) begin rdy_cyc = c; cpu_req = 1'b0; end
    end
    cpu_exp = 32'h0BADF00D;
    tests++;
    if (strobes != 2 || first_wr !== 1'b1)
      begin fails++; $display("FAIL both_strobes: got %0d first_wr %b expected 2 1", strobes, first_wr); end
    tests++;
    if (done_cyc != 4 || rdy_cyc != 9)
      begin fails++; $display("FAIL both_order: got done %0d ready %0d expected 4 9", done_cyc, rdy_cyc); end
    tests++;
    if (cpu_data_out !== cpu_exp)
      begin fails++; $display("FAIL both_data: got %h expected %h", cpu_data_out, cpu_exp); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0, rdy_cyc = -1;
    mem_lat = 0; stray_mode = 0;
    vga_addr = 22'h777; vga_req = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    #1;
    tests++;
    if ({cpu_ready, cpu_done, vga_ready, mem_req, mem_write, timeout_err, busy, grant_vga} !== 8'b0 ||
        {mem_addr, mem_data_out, cpu_data_out, vga_data_out} !== '0)
      begin fails++; $display("FAIL mid_reset: got ctrl %b addr %h data %h %h %h expected all 0",
        {cpu_ready, cpu_done, vga_ready, mem_req, mem_write, timeout_err, busy, grant_vga},
        mem_addr, mem_data_out, cpu_data_out, vga_data_out); end
    vga_req = 1'b0;
    step(); step();
    reset = 1'b0;
    cpu_exp = '0; vga_exp = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (cpu_ready || cpu_done || vga_ready || timeout_err || busy) pulses++;
    end
    tests++;
    if (pulses != 0)
      begin fails++; $display("FAIL mid_no_resp: got %0d active cycles expected 0", pulses); end
    mem_lat = 2; mem_rd_value = 32'h600DCAFE;
    cpu_addr = 22'h55; cpu_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (cpu_ready && rdy_cyc < 0) begin rdy_cyc = c; cpu_req = 1'b0; end
    end
    cpu_exp = 32'h600DCAFE;
    tests++;
    if (rdy_cyc != 4 || cpu_data_out !== cpu_exp)
      begin fails++; $display("FAIL mid_after: got cycle %0d data %h expected 4 %h",
        rdy_cyc, cpu_data_out, cpu_exp); end
  endtask

  task automatic test_random();
    int starve_m = 0;
    bit v_p = 0, cr_p = 0, cw_p = 0;
    for (int it = 0; it < 60; it++) begin
      bit cpu_p, win_v, wr, abort, bad;
      int lat, nwait;
      logic [DW-1:0] rdv;
      logic [AW-1:0] exp_addr;
      logic [3:0] exp_p;
      if (!v_p && $urandom_range(0, 1) == 1) begin v_p = 1; vga_addr = AW'($urandom); end
      if (!cr_p && !cw_p && $urandom_range(0, 1) == 1) begin
        cpu_addr = AW'($urandom); cpu_data_in = DW'($urandom);
        case ($urandom_range(0, 2))
          0:       cr_p = 1;
          1:       cw_p = 1;
          default: begin cr_p = 1; cw_p = 1; end
        endcase
      end
      vga_req = v_p; cpu_req = cr_p; cpu_write = cw_p;
      cpu_p = cr_p || cw_p;
      if (!v_p && !cpu_p) begin
        step();
        tests++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || mem_write !== 1'b0)
          begin fails++; $display("FAIL rnd_idle: got busy %b req %b wr %b expected 0 0 0",
            busy, mem_req, mem_write); end
        continue;
      end
      win_v = v_p && !(cpu_p && starve_m >= STARVE);
      wr = !win_v && cw_p;
      if (win_v) begin
        if (cpu_p && starve_m < 15) starve_m++;
      end else starve_m = 0;
      lat = $urandom_range(0, 6);
      abort = (lat == 0);
      nwait = abort ? TMO : lat;
      rdv = DW'($urandom);
      mem_lat = lat; mem_rd_value = rdv; stray_mode = 1;
      exp_addr = win_v ? vga_addr : cpu_addr;
      step();
      tests++;
      if ({mem_req, mem_write} !== (wr ? 2'b01 : 2'b10))
        begin fails++; $display("FAIL rnd_strobe%0d: got req %b wr %b expected wr=%b",
          it, mem_req, mem_write, wr); end
      tests++;
      if (grant_vga !== win_v || mem_addr !== exp_addr || (wr && mem_data_out !== cpu_data_in))
        begin fails++; $display("FAIL rnd_grant%0d: got vga %b addr %h data %h expected %b %h %h",
          it, grant_vga, mem_addr, mem_data_out, win_v, exp_addr, cpu_data_in); end
      bad = 0;
      for (int k = 1; k <= nwait; k++) begin
        step();
        if (!busy || cpu_ready || cpu_done || vga_ready || timeout_err || mem_req || mem_write) bad = 1;
      end
      tests++;
      if (bad)
        begin fails++; $display("FAIL rnd_wait%0d: got early activity expected %0d quiet busy cycles",
          it, nwait); end
      step();
      if (win_v) begin
        vga_exp = abort ? '1 : rdv; exp_p = {3'b001, abort}; v_p = 0;
      end else if (wr) begin
        exp_p = {3'b010, abort}; cw_p = 0;
      end else begin
        cpu_exp = abort ? '1 : rdv; exp_p = {3'b100, abort}; cr_p = 0;
      end
      tests++;
      if ({cpu_ready, cpu_done, vga_ready, timeout_err} !== exp_p)
        begin fails++; $display("FAIL rnd_resp%0d: got %b expected %b",
          it, {cpu_ready, cpu_done, vga_ready, timeout_err}, exp_p); end
      tests++;
      if (cpu_data_out !== cpu_exp || vga_data_out !== vga_exp)
        begin fails++; $display("FAIL rnd_data%0d: got cpu %h vga %h expected %h %h",
          it, cpu_data_out, vga_data_out, cpu_exp, vga_exp); end
      vga_req = v_p; cpu_req = cr_p; cpu_write = cw_p;
      step();
      tests++;
      if (busy !== 1'b0 || {cpu_ready, cpu_done, vga_ready, timeout_err} !== 4'b0)
        begin fails++; $display("FAIL rnd_idle_after%0d: got busy %b pulses %b expected 0 0000",
          it, busy, {cpu_ready, cpu_done, vga_ready, timeout_err}); end
    end
    stray_mode = 0;
    vga_req = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_contention();
    test_timeout();
    test_write_and_read();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
